mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: WAIT_STATES, default 1, memory wait cycles per access (legal range 0-15).
REQ-002 Parameter: AW, default 16, address width; DW, default 32, data width.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  instruction-fetch request; held until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DW  fetched word.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  data write (1) or read (0).
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DW  load data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid in the final ACCESS cycle.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 The block SHALL share one single-port memory between the fetch port and the data port using FSM states IDLE, ACCESS and RESP.
REQ-005 In IDLE with no request pending, the FSM SHALL stay in IDLE and mem_en, mem_we, if_ack and dm_ack SHALL be 0.
REQ-006 In IDLE with a request pending, the block SHALL register the winning port's address, we and wdata, load wcnt=WAIT_STATES, and go to ACCESS on the next edge.
REQ-007 Arbitration SHALL be round-robin on the last_grant flag:
- single requester: that requester wins;
- both requesting: the port not granted last wins;
- last_grant SHALL update on every grant.
REQ-008 In ACCESS the block SHALL drive mem_en=1, with mem_addr and mem_wdata taken from the registers; mem_we=1 only for a data write.
REQ-009 ACCESS SHALL last WAIT_STATES+1 cycles:
- wcnt SHALL decrement each cycle;
- at wcnt==0 the block SHALL capture mem_rdata into the granted port's rdata register (reads only) and go to RESP.
REQ-010 In RESP the block SHALL pulse exactly one of if_ack or dm_ack for one cycle, then return to IDLE.
REQ-011 Latency SHALL be WAIT_STATES+2 cycles from the request being sampled in IDLE to the ack cycle; a new grant SHALL be possible on the cycle after RESP.
REQ-012 Deassertion of req after a grant SHALL NOT abort the access; the ack SHALL still pulse.
REQ-013 A write access SHALL leave dm_rdata unchanged.
REQ-014 The if_rdata and dm_rdata registers SHALL hold their value until the next read on that port.
REQ-015 A request arriving during ACCESS or RESP SHALL wait and be arbitrated in the next IDLE cycle.

Reset
REQ-016 Asserting rst SHALL immediately force the following, including mid-access:
- state=IDLE, wcnt=0, last_grant=IF;
- all outputs to 0, including if_rdata and dm_rdata;
- no ack SHALL be issued for an interrupted access.
REQ-017 After rst deasserts, the first contended grant SHALL go to the data port.

Configuration
REQ-018 With MEM_ARB_STATS_EN defined, the block SHALL add these outputs:
- if_grants[15:0] and dm_grants[15:0], which SHALL increment per grant and wrap at 0xFFFF;
- contention_cnt[15:0], which SHALL increment on each IDLE cycle where both req are high, and wrap at 0xFFFF;
- all three counters SHALL reset to 0.
REQ-019 Without MEM_ARB_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-020 A shared package SHALL hold:
- the state encoding (IDLE=0, ACCESS=1, RESP=2);
- port IDs IF=0, DM=1;
- the default WAIT_STATES.
REQ-021 The wait counter SHALL be a sub-module named wait_cnt (load, decrement, zero flag); everything else SHALL be in mem_arb.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- WAIT_STATES=1; if_req, if_addr=0x0010, mem_rdata=0xDEADBEEF -> if_ack at cycle 3 with if_rdata=0xDEADBEEF.
- dm_req with dm_we=1, dm_addr=0x0100, dm_wdata=0x12345678 -> mem_we=1 for 2 cycles, dm_ack at cycle 3, dm_rdata unchanged.
- Both req high from reset, held -> grants alternate DM, IF, DM, IF; acks 4 cycles apart.
- rst asserted during ACCESS -> outputs 0 at once, no ack; a later if_req completes normally.
- WAIT_STATES=0 -> ack at cycle 2; if_req dropped after grant -> if_ack still pulses once.
- MEM_ARB_STATS_EN defined, 3 contended cycles -> contention_cnt=3; if_grants+dm_grants equals the number of completed accesses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb fetch/data memory arbiter:
// FSM state encoding, port identifiers and the round-robin pick function.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_id_t;

   localparam int DEFAULT_WAIT_STATES = 1;
   localparam int WCNT_W              = 4;

   // Round-robin winner: a lone requester wins, a tie goes to the port not granted last.
   function automatic port_id_t pick_port(input logic if_req, input logic dm_req,
                                          input port_id_t last);
      port_id_t win;
      if (if_req && dm_req) begin
         win = (last == PORT_IF) ? PORT_DM : PORT_IF;
      end else if (dm_req) begin
         win = PORT_DM;
      end else begin
         win = PORT_IF;
      end
      return win;
   endfunction

endpackage

// File: rtl/wait_cnt.sv
// Memory wait-state counter for mem_arb: loadable, decrementing, with a zero flag.
module wait_cnt
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WCNT_W-1:0] load_val,
   input  logic              dec,
   output logic              zero
);

   logic [WCNT_W-1:0] cnt_r;

   // Counter register: load wins over decrement and the count never wraps below zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {WCNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {WCNT_W{1'b0}})) begin
         cnt_r <= cnt_r - {{(WCNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {WCNT_W{1'b0}});

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-port memory between fetch and data ports.
// Optional grant/contention statistics outputs are enabled by defining MEM_ARB_STATS_EN.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
   parameter int AW          = 16,
   parameter int DW          = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]   if_grants,
   output logic [15:0]   dm_grants,
   output logic [15:0]   contention_cnt
`endif
);

   localparam logic [WCNT_W-1:0] WS_L = WCNT_W'(WAIT_STATES);

   arb_state_t    state_r, state_s;
   port_id_t      gnt_r, last_grant_r, win_s;
   logic          grant_s, zero_s, dec_s, done_s, sel_we_s;
   logic          we_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r, if_rdata_r, dm_rdata_r;
   logic          mem_en_r, mem_we_r, if_ack_r, dm_ack_r, busy_r;

   wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (grant_s),
      .load_val (WS_L),
      .dec      (dec_s),
      .zero     (zero_s)
   );

   // Next-state decode; a grant is only taken from IDLE.
   always_comb begin
      state_s = state_r;
      grant_s = 1'b0;
      win_s   = pick_port(if_req, dm_req, last_grant_r);
      case (state_r)
         IDLE: begin
            if (if_req || dm_req) begin
               grant_s = 1'b1;
               state_s = ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (zero_s) begin
               state_s = RESP;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign dec_s    = (state_r == ACCESS);
   assign done_s   = (state_r == ACCESS) && zero_s;
   assign sel_we_s = grant_s ? ((win_s == PORT_DM) && dm_we) : we_r;

   // State register and per-access request latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         gnt_r        <= PORT_IF;
         last_grant_r <= PORT_IF;
         we_r         <= 1'b0;
         addr_r       <= {AW{1'b0}};
         wdata_r      <= {DW{1'b0}};
      end else begin
         state_r <= state_s;
         if (grant_s) begin
            gnt_r        <= win_s;
            last_grant_r <= win_s;
            we_r         <= (win_s == PORT_DM) && dm_we;
            addr_r       <= (win_s == PORT_DM) ? dm_addr : if_addr;
            wdata_r      <= (win_s == PORT_DM) ? dm_wdata : {DW{1'b0}};
         end
      end
   end

   // Strobes are registered from the next state so they line up with ACCESS/RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en_r <= 1'b0;
         mem_we_r <= 1'b0;
         if_ack_r <= 1'b0;
         dm_ack_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         mem_en_r <= (state_s == ACCESS);
         mem_we_r <= (state_s == ACCESS) && sel_we_s;
         if_ack_r <= (state_s == RESP) && (gnt_r == PORT_IF);
         dm_ack_r <= (state_s == RESP) && (gnt_r == PORT_DM);
         busy_r   <= (state_s != IDLE);
      end
   end

   // Read data capture in the last ACCESS cycle; writes leave both registers alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_rdata_r <= {DW{1'b0}};
         dm_rdata_r <= {DW{1'b0}};
      end else if (done_s && !we_r) begin
         if (gnt_r == PORT_IF) begin
            if_rdata_r <= mem_rdata;
         end else begin
            dm_rdata_r <= mem_rdata;
         end
      end
   end

   assign if_ack    = if_ack_r;
   assign dm_ack    = dm_ack_r;
   assign if_rdata  = if_rdata_r;
   assign dm_rdata  = dm_rdata_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign busy      = busy_r;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] if_grants_r, dm_grants_r, contention_r;

   // Free-running statistics, wrapping naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_grants_r  <= 16'd0;
         dm_grants_r  <= 16'd0;
         contention_r <= 16'd0;
      end else begin
         if (grant_s && (win_s == PORT_IF)) if_grants_r <= if_grants_r + 16'd1;
         if (grant_s && (win_s == PORT_DM)) dm_grants_r <= dm_grants_r + 16'd1;
         if ((state_r == IDLE) && if_req && dm_req) contention_r <= contention_r + 16'd1;
      end
   end

   assign if_grants      = if_grants_r;
   assign dm_grants      = dm_grants_r;
   assign contention_cnt = contention_r;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb: one instance with WAIT_STATES=1, one with 0.
module tb_mem_arb;

   logic        clk, rst;
   logic        if_req, dm_req, dm_we;
   logic [15:0] if_addr, dm_addr;
   logic [31:0] dm_wdata, mem_rdata;
   logic        if_ack, dm_ack, mem_en, mem_we, busy;
   logic [31:0] if_rdata, dm_rdata, mem_wdata;
   logic [15:0] mem_addr;

   logic        z_if_req;
   logic [15:0] z_if_addr;
   logic [31:0] z_mem_rdata;
   logic        z_if_ack, z_dm_ack, z_mem_en, z_mem_we, z_busy;
   logic [31:0] z_if_rdata, z_dm_rdata, z_mem_wdata;
   logic [15:0] z_mem_addr;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] if_grants, dm_grants, contention_cnt;
   logic [15:0] z_if_grants, z_dm_grants, z_contention_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   mem_arb #(.WAIT_STATES(1), .AW(16), .DW(32)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
      , .if_grants(if_grants), .dm_grants(dm_grants), .contention_cnt(contention_cnt)
`endif
   );

   mem_arb #(.WAIT_STATES(0), .AW(16), .DW(32)) u_dut0 (
      .clk(clk), .rst(rst),
      .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0000_0000),
      .dm_ack(z_dm_ack), .dm_rdata(z_dm_rdata),
      .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
      .mem_rdata(z_mem_rdata), .busy(z_busy)
`ifdef MEM_ARB_STATS_EN
      , .if_grants(z_if_grants), .dm_grants(z_dm_grants), .contention_cnt(z_contention_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = 16'h0000; dm_addr = 16'h0000; dm_wdata = 32'h0; mem_rdata = 32'h0;
      z_if_req = 1'b0; z_if_addr = 16'h0000; z_mem_rdata = 32'h0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_acks", {if_ack, dm_ack}, 2'b00);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      rst = 1'b0;

      // Instruction fetch, WAIT_STATES=1: ack in cycle 3
      if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 32'hDEAD_BEEF;
      tick(1);
      chk("if_c1_en", {busy, mem_en, mem_we}, 3'b110);
      chk("if_c1_addr", mem_addr, 16'h0010);
      chk("if_c1_ack", if_ack, 1'b0);
      tick(1);
      chk("if_c2_en", mem_en, 1'b1);
      chk("if_c2_ack", if_ack, 1'b0);
      tick(1);
      chk("if_c3_ack", {if_ack, dm_ack}, 2'b10);
      chk("if_c3_en", mem_en, 1'b0);
      chk("if_rdata", if_rdata, 32'hDEAD_BEEF);
      if_req = 1'b0;
      tick(1);
      chk("if_c4_idle", {busy, if_ack}, 2'b00);
      chk("if_rdata_hold", if_rdata, 32'hDEAD_BEEF);

      // Data write: mem_we for two cycles, dm_rdata untouched
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 32'h1234_5678;
      mem_rdata = 32'hCAFE_F00D;
      tick(1);
      chk("wr_c1_we", {mem_en, mem_we}, 2'b11);
      chk("wr_c1_addr", mem_addr, 16'h0100);
      chk("wr_c1_wdata", mem_wdata, 32'h1234_5678);
      tick(1);
      chk("wr_c2_we", mem_we, 1'b1);
      chk("wr_c2_ack", dm_ack, 1'b0);
      tick(1);
      chk("wr_c3_ack", {if_ack, dm_ack, mem_we}, 3'b010);
      chk("wr_dm_rdata", dm_rdata, 32'h0000_0000);
      dm_req = 1'b0; dm_we = 1'b0;
      tick(1);
      chk("wr_c4_ack", dm_ack, 1'b0);
      chk("wr_if_rdata_hold", if_rdata, 32'hDEAD_BEEF);

      // Contention from reset: DM, IF, DM, IF, acks 4 cycles apart
      rst = 1'b1;
      tick(1);
      chk("rst2_if_rdata", if_rdata, 32'h0000_0000);
      rst = 1'b0;
      if_req = 1'b1; dm_req = 1'b1; if_addr = 16'h0020; dm_addr = 16'h0200;
      mem_rdata = 32'h1111_1111;
      tick(1);
      chk("rr1_addr", mem_addr, 16'h0200);
      tick(2);
      chk("rr1_ack", {if_ack, dm_ack}, 2'b01);
      chk("rr1_rdata", dm_rdata, 32'h1111_1111);
      mem_rdata = 32'h2222_2222;
      tick(1);
      chk("rr1_idle", {busy, if_ack, dm_ack}, 3'b000);
      tick(1);
      chk("rr2_addr", mem_addr, 16'h0020);
      tick(2);
      chk("rr2_ack", {if_ack, dm_ack}, 2'b10);
      chk("rr2_rdata", if_rdata, 32'h2222_2222);
      chk("rr2_dm_hold", dm_rdata, 32'h1111_1111);
      mem_rdata = 32'h3333_3333;
      tick(2);
      chk("rr3_addr", mem_addr, 16'h0200);
      tick(2);
      chk("rr3_ack", {if_ack, dm_ack}, 2'b01);
      chk("rr3_rdata", dm_rdata, 32'h3333_3333);
      dm_req = 1'b0;
      tick(2);
      chk("rr4_addr", mem_addr, 16'h0020);
      tick(2);
      chk("rr4_ack", {if_ack, dm_ack}, 2'b10);
      chk("rr4_rdata", if_rdata, 32'h3333_3333);
      if_req = 1'b0;
      tick(1);
`ifdef MEM_ARB_STATS_EN
      chk("st_contention", contention_cnt, 16'd3);
      chk("st_grants_sum", 32'(if_grants) + 32'(dm_grants), 32'd4);
      chk("st_dm_grants", dm_grants, 16'd2);
`endif

      // Reset in the middle of an access
      if_req = 1'b1; if_addr = 16'h0030; mem_rdata = 32'h4444_4444;
      tick(1);
      chk("ra_en_before", mem_en, 1'b1);
      rst = 1'b1;
      #1;
      chk("ra_outs", {busy, mem_en, mem_we, if_ack, dm_ack}, 5'b00000);
      chk("ra_if_rdata", if_rdata, 32'h0000_0000);
      chk("ra_dm_rdata", dm_rdata, 32'h0000_0000);
      chk("ra_mem_addr", mem_addr, 16'h0000);
      if_req = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(3);
      chk("ra_no_ack", {busy, if_ack, dm_ack}, 3'b000);
      if_req = 1'b1; if_addr = 16'h0040; mem_rdata = 32'h5555_5555;
      tick(3);
      chk("ra_new_ack", if_ack, 1'b1);
      chk("ra_new_rdata", if_rdata, 32'h5555_5555);
      if_req = 1'b0;
      tick(1);

      // WAIT_STATES=0: ack in cycle 2, request dropped right after the grant
      z_if_req = 1'b1; z_if_addr = 16'h0050; z_mem_rdata = 32'h6666_6666;
      tick(1);
      chk("z_c1_en", {z_mem_en, z_busy}, 2'b11);
      chk("z_c1_addr", z_mem_addr, 16'h0050);
      z_if_req = 1'b0;
      tick(1);
      chk("z_c2_ack", {z_if_ack, z_dm_ack}, 2'b10);
      chk("z_rdata", z_if_rdata, 32'h6666_6666);
      tick(1);
      chk("z_c3_ack", {z_if_ack, z_busy}, 2'b00);
      tick(1);
      chk("z_c4_ack", {z_if_ack, z_mem_en}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
